// File: rtl/s100_io_responder.sv
// S-100 bus I/O-port responder.
// Decodes Z80 port cycles aimed at a small address window, stretches them with
// RDY wait states, captures OUT data into two byte registers (LED latch at
// offset 0, scratch at offset 1) and sources those registers back on IN cycles.
// Every bus input is resynchronised to clockIn before any decision is made.
module s100_io_responder #(
  parameter logic [7:0]  PORT_BASE   = 8'h40,
  parameter logic [7:0]  PORT_MASK   = 8'hFE,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic       clockIn,
  input  logic       sw1_reset_n,
  input  logic       s100_pSYNC,
  input  logic       s100_sINP,
  input  logic       s100_sOUT,
  input  logic [7:0] s100_adr,
  input  logic       s100_pDBIN,
  input  logic       s100_n_pWR,
  input  logic [7:0] s100_DO,
  output logic       rdy_pull,
  output logic [7:0] di_data,
  output logic       di_oe,
  output logic [7:0] led_reg,
  output logic [7:0] scratch_reg,
  output logic       wr_strobe,
  output logic       timeout_err
);

  // Wait-state load value; the counter is 8 bits wide like the timeout counter.
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  // All asynchronous bus inputs, grouped so one synchroniser chain covers them.
  typedef struct packed {
    logic       psync;
    logic       sinp;
    logic       sout;
    logic       pdbin;
    logic       n_pwr;
    logic [7:0] adr;
    logic [7:0] dout;
  } bus_t;

  // Quiescent bus: strobes inactive, n_pWR high so reset release never looks
  // like a write-strobe fall.
  localparam bus_t BUS_IDLE = '{psync: 1'b0, sinp: 1'b0, sout: 1'b0,
                                pdbin: 1'b0, n_pwr: 1'b1,
                                adr: 8'h00, dout: 8'h00};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  bus_t       bus_raw;
  bus_t       bus_meta;
  bus_t       bus_sync;
  logic       psync_d;
  logic       pdbin_d;
  logic       n_pwr_d;

  state_t     state, state_n;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       lat_adr0, lat_adr0_n;
  logic       lat_read, lat_read_n;
  logic [7:0] di_data_n;
  logic [7:0] led_n;
  logic [7:0] scratch_n;
  logic       timeout_err_n;

  logic       psync_rise;
  logic       pdbin_fall;
  logic       n_pwr_fall;
  logic       addr_match;
  logic       hit;

  assign bus_raw = {s100_pSYNC, s100_sINP, s100_sOUT, s100_pDBIN, s100_n_pWR,
                    s100_adr, s100_DO};

  // Two-flop synchroniser plus one delayed copy of the strobes for edge detect.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clockIn or negedge sw1_reset_n) begin
    if (!sw1_reset_n) begin
      bus_meta <= BUS_IDLE;
      bus_sync <= BUS_IDLE;
      psync_d  <= 1'b0;
      pdbin_d  <= 1'b0;
      n_pwr_d  <= 1'b1;
    end else begin
      bus_meta <= bus_raw;
      bus_sync <= bus_meta;
      psync_d  <= bus_sync.psync;
      pdbin_d  <= bus_sync.pdbin;
      n_pwr_d  <= bus_sync.n_pwr;
    end
  end

  assign psync_rise = bus_sync.psync & ~psync_d;
  assign pdbin_fall = ~bus_sync.pdbin & pdbin_d;
  assign n_pwr_fall = ~bus_sync.n_pwr & n_pwr_d;

  // A cycle is ours only when exactly one of sINP/sOUT is set and the
  // compared address bits land in the window.
  assign addr_match = (bus_sync.adr & PORT_MASK) == (PORT_BASE & PORT_MASK);
  assign hit        = (bus_sync.sinp ^ bus_sync.sout) & addr_match;

  // State, counters, latched cycle info and the two byte registers.
  always_ff @(posedge clockIn or negedge sw1_reset_n) begin
    if (!sw1_reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'h00;
      tmo_cnt     <= 8'h00;
      lat_adr0    <= 1'b0;
      lat_read    <= 1'b0;
      di_data     <= 8'h00;
      led_reg     <= 8'h00;
      scratch_reg <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      lat_adr0    <= lat_adr0_n;
      lat_read    <= lat_read_n;
      di_data     <= di_data_n;
      led_reg     <= led_n;
      scratch_reg <= scratch_n;
      timeout_err <= timeout_err_n;
    end
  end

  // Next-state decode, register updates and the bus-facing strobes.
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips it would infer a latch.
  always_comb begin
    state_n       = state;
    wait_cnt_n    = wait_cnt;
    tmo_cnt_n     = tmo_cnt;
    lat_adr0_n    = lat_adr0;
    lat_read_n    = lat_read;
    di_data_n     = di_data;
    led_n         = led_reg;
    scratch_n     = scratch_reg;
    timeout_err_n = timeout_err;
    rdy_pull      = 1'b0;
    di_oe         = 1'b0;
    wr_strobe     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (psync_rise && hit) begin
          lat_adr0_n = bus_sync.adr[0];
          lat_read_n = bus_sync.sinp;
          if (WAIT_CYCLES == 0) begin
            state_n   = S_XFER;
            tmo_cnt_n = 8'h00;
            di_data_n = bus_sync.adr[0] ? scratch_reg : led_reg;
          end else begin
            state_n    = S_WAIT;
            wait_cnt_n = WAIT_INIT;
          end
        end
      end

      S_WAIT: begin
        rdy_pull   = 1'b1;
        wait_cnt_n = wait_cnt - 8'd1;
        if (wait_cnt == 8'd1) begin
          state_n   = S_XFER;
          tmo_cnt_n = 8'h00;
          di_data_n = lat_adr0 ? scratch_reg : led_reg;
        end
      end

      S_XFER: begin
        tmo_cnt_n = tmo_cnt + 8'd1;
        if (lat_read) begin
          di_oe = bus_sync.pdbin;
          if (pdbin_fall) begin
            state_n = S_DONE;
          end else if (tmo_cnt == TIMEOUT) begin
            timeout_err_n = 1'b1;
            state_n       = S_IDLE;
          end
        end else begin
          if (n_pwr_fall) begin
            wr_strobe = 1'b1;
            if (lat_adr0) scratch_n = bus_sync.dout;
            else          led_n     = bus_sync.dout;
            state_n = S_DONE;
          end else if (tmo_cnt == TIMEOUT) begin
            timeout_err_n = 1'b1;
            state_n       = S_IDLE;
          end
        end
      end

      S_DONE: begin
        if (!bus_sync.psync && !bus_sync.pdbin && bus_sync.n_pwr) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_s100_io_responder.sv
// Self-checking bench for s100_io_responder.
// Two instances share the bus: dut has the default 4 wait states, dut_nw is
// built with WAIT_CYCLES=0. Expected register/read values come from a small
// byte-register model and travel through per-instance scoreboard queues.
module tb_s100_io_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psync;
  logic       sinp;
  logic       sout;
  logic [7:0] adr;
  logic       pdbin;
  logic       n_pwr;
  logic [7:0] dout;

  logic       rdy_pull,  di_oe,  wr_strobe,  timeout_err;
  logic [7:0] di_data,   led_reg,   scratch_reg;
  logic       rdy_pull0, di_oe0, wr_strobe0, timeout_err0;
  logic [7:0] di_data0,  led_reg0,  scratch_reg0;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy0_total = 0;

  logic [7:0] model_led = 8'h00;
  logic [7:0] model_scr = 8'h00;
  logic [7:0] sb_q[$];
  logic [7:0] sb0_q[$];

  always #5 clk = ~clk;

  s100_io_responder dut (
    .clockIn    (clk),
    .sw1_reset_n(rst_n),
    .s100_pSYNC (psync),
    .s100_sINP  (sinp),
    .s100_sOUT  (sout),
    .s100_adr   (adr),
    .s100_pDBIN (pdbin),
    .s100_n_pWR (n_pwr),
    .s100_DO    (dout),
    .rdy_pull   (rdy_pull),
    .di_data    (di_data),
    .di_oe      (di_oe),
    .led_reg    (led_reg),
    .scratch_reg(scratch_reg),
    .wr_strobe  (wr_strobe),
    .timeout_err(timeout_err)
  );

  s100_io_responder #(.WAIT_CYCLES(0)) dut_nw (
    .clockIn    (clk),
    .sw1_reset_n(rst_n),
    .s100_pSYNC (psync),
    .s100_sINP  (sinp),
    .s100_sOUT  (sout),
    .s100_adr   (adr),
    .s100_pDBIN (pdbin),
    .s100_n_pWR (n_pwr),
    .s100_DO    (dout),
    .rdy_pull   (rdy_pull0),
    .di_data    (di_data0),
    .di_oe      (di_oe0),
    .led_reg    (led_reg0),
    .scratch_reg(scratch_reg0),
    .wr_strobe  (wr_strobe0),
    .timeout_err(timeout_err0)
  );

  // The no-wait instance must never stretch a cycle.
  always @(negedge clk) if (rdy_pull0) rdy0_total++;

  // One complete bus cycle. Samples on every falling edge, drives right after.
  // pSYNC high for two cycles, strobe (pDBIN or n_pWR) from c=15 to c=19.
  task automatic bus_cycle(input logic [7:0] a, input logic i_in, input logic i_out,
                           input logic is_wr, input logic [7:0] d, input logic hit);
    int   rdy_n = 0, oe_n = 0, oe_early = 0, stb_n = 0;
    bit   got = 0, got0 = 0;
    logic [7:0] exp_v;
    if (hit) begin
      exp_v = is_wr ? d : (a[0] ? model_scr : model_led);
      sb_q.push_back(exp_v);
      sb0_q.push_back(exp_v);
      if (is_wr) begin
        if (a[0]) model_scr = d;
        else      model_led = d;
      end
    end
    @(negedge clk);
    adr = a; sinp = i_in; sout = i_out; dout = d; psync = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (rdy_pull) rdy_n++;
      if (wr_strobe) begin
        stb_n++;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
      if (wr_strobe0 && sb0_q.size() != 0) void'(sb0_q.pop_front());
      if (di_oe) begin
        oe_n++;
        if (c <= 15) oe_early++;
        if (!got && sb_q.size() != 0) begin
          got = 1;
          exp_v = sb_q.pop_front();
          n_cmp++;
          if (di_data !== exp_v) begin
            n_bad++;
            $display("FAIL di_data port %h: got %h expected %h", a, di_data, exp_v);
          end
        end
      end
      if (di_oe0 && !got0 && sb0_q.size() != 0) begin
        got0 = 1;
        exp_v = sb0_q.pop_front();
        n_cmp++;
        if (di_data0 !== exp_v) begin
          n_bad++;
          $display("FAIL nowait di_data port %h: got %h expected %h", a, di_data0, exp_v);
        end
      end
      if (c == 1) psync = 1'b0;
      if (c == 15) begin
        if (is_wr) n_pwr = 1'b0;
        else       pdbin = 1'b1;
      end
      if (c == 19) begin
        n_pwr = 1'b1;
        pdbin = 1'b0;
      end
    end
    sinp = 1'b0; sout = 1'b0;

    n_cmp++;
    if (rdy_n !== (hit ? 4 : 0)) begin
      n_bad++;
      $display("FAIL rdy_cycles port %h: got %0d expected %0d", a, rdy_n, hit ? 4 : 0);
    end
    n_cmp++;
    if (stb_n !== ((hit && is_wr) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL wr_strobe_count port %h: got %0d expected %0d", a, stb_n, (hit && is_wr) ? 1 : 0);
    end
    n_cmp++;
    if ((oe_n > 0) !== (hit && !is_wr)) begin
      n_bad++;
      $display("FAIL di_oe_seen port %h: got %0d cycles expected %0s", a, oe_n,
               (hit && !is_wr) ? "some" : "none");
    end
    n_cmp++;
    if (oe_early !== 0) begin
      n_bad++;
      $display("FAIL di_oe_before_pdbin port %h: got %0d expected 0", a, oe_early);
    end
    n_cmp++;
    if (sb_q.size() !== 0 || sb0_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain port %h: got %0d/%0d left expected 0/0", a, sb_q.size(), sb0_q.size());
      sb_q.delete();
      sb0_q.delete();
    end
    n_cmp++;
    if (led_reg !== model_led || scratch_reg !== model_scr) begin
      n_bad++;
      $display("FAIL regs port %h: got led=%h scr=%h expected led=%h scr=%h",
               a, led_reg, scratch_reg, model_led, model_scr);
    end
    n_cmp++;
    if (led_reg0 !== model_led || scratch_reg0 !== model_scr) begin
      n_bad++;
      $display("FAIL nowait_regs port %h: got led=%h scr=%h expected led=%h scr=%h",
               a, led_reg0, scratch_reg0, model_led, model_scr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psync = 1'b0; sinp = 1'b0; sout = 1'b0; adr = 8'h00;
    pdbin = 1'b0; n_pwr = 1'b1; dout = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rdy_pull, di_oe, wr_strobe, timeout_err, di_data, led_reg, scratch_reg} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b oe=%b stb=%b to=%b di=%h led=%h scr=%h expected all 0",
               rdy_pull, di_oe, wr_strobe, timeout_err, di_data, led_reg, scratch_reg);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_out_led();
    bus_cycle(8'h40, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
  endtask

  task automatic test_out_in_scratch();
    bus_cycle(8'h41, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
    bus_cycle(8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    bus_cycle(8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_ignored();
    bus_cycle(8'h42, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    bus_cycle(8'h40, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
    bus_cycle(8'hC0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
  endtask

  // IN 40h with no pDBIN. Drive at negedge N0; 2 sync + 1 decode + 4 wait
  // edges reach XFER at posedge 7, counter hits 255 at posedge 262, the abort
  // edge is posedge 263, first visible at loop sample c=262.
  task automatic test_timeout();
    int rdy_n = 0, oe_n = 0, first_c = -1;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_err_pre: got %b expected 0", timeout_err);
    end
    @(negedge clk);
    adr = 8'h40; sinp = 1'b1; sout = 1'b0; psync = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rdy_pull) rdy_n++;
      if (di_oe) oe_n++;
      if (timeout_err && first_c < 0) first_c = c;
      if (c == 1) psync = 1'b0;
    end
    sinp = 1'b0;
    n_cmp++;
    if (first_c !== 262) begin
      n_bad++;
      $display("FAIL timeout_cycle: got %0d expected 262", first_c);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || timeout_err0 !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err: got %b/%b expected 1/1", timeout_err, timeout_err0);
    end
    n_cmp++;
    if (oe_n !== 0 || rdy_n !== 4) begin
      n_bad++;
      $display("FAIL timeout_bus: got oe=%0d rdy=%0d expected oe=0 rdy=4", oe_n, rdy_n);
    end
    // Back in IDLE: a fresh write must decode, and the error stays sticky.
    bus_cycle(8'h41, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen = -1;
    @(negedge clk);
    adr = 8'h40; sinp = 1'b0; sout = 1'b1; dout = 8'h99; psync = 1'b1;
    for (int c = 0; c < 20 && seen < 0; c++) begin
      @(negedge clk);
      if (rdy_pull) seen = c;
      if (c == 1) psync = 1'b0;
    end
    n_cmp++;
    if (seen < 0) begin
      n_bad++;
      $display("FAIL reset_wait_entry: got no rdy_pull expected rdy_pull within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy_pull, di_oe, wr_strobe, timeout_err, led_reg, scratch_reg} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_async: got rdy=%b oe=%b stb=%b to=%b led=%h scr=%h expected all 0",
               rdy_pull, di_oe, wr_strobe, timeout_err, led_reg, scratch_reg);
    end
    psync = 1'b0; sout = 1'b0;
    model_led = 8'h00; model_scr = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_cycle(8'h40, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
  endtask

  task automatic test_no_wait();
    bus_cycle(8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (rdy0_total !== 0) begin
      n_bad++;
      $display("FAIL nowait_rdy: got %0d cycles expected 0", rdy0_total);
    end
  endtask

  initial begin
    test_reset();
    test_out_led();
    test_out_in_scratch();
    test_ignored();
    test_timeout();
    test_reset_mid_wait();
    test_no_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
